// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: parametrised GPIO block on the simple register bus.
// Per-pin direction/data, atomic SET/CLR, 2-flop input synchroniser, rise/fall
// edge capture into a W1C STATUS register and a level interrupt line.
// Optional input debounce filter is enabled with the macro GPIO_DEBOUNCE_EN.
module gpio_irq_ctrl #(
  parameter int unsigned GPIO_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            addr_i,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq_o
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_PIN     = 3'd2,
    REG_SET     = 3'd3,
    REG_CLR     = 3'd4,
    REG_RISE_EN = 3'd5,
    REG_FALL_EN = 3'd6,
    REG_STATUS  = 3'd7
  } reg_idx_e;

  logic [GPIO_WIDTH-1:0] r_data, r_dir, r_rise_en, r_fall_en, r_status;
  logic [GPIO_WIDTH-1:0] r_sync1, r_sync2, r_filt, r_prev;
  logic [1:0]            r_arm_cnt;

  reg_idx_e              w_idx;
  logic [GPIO_WIDTH-1:0] w_wd, w_pin, w_rise, w_fall, w_set, w_w1c;
  logic                  w_armed, w_arming;
  logic [31:0]           w_rmux;
  logic                  w_unused;

  assign w_idx    = reg_idx_e'(addr_i[4:2]);
  assign w_wd     = wdata[GPIO_WIDTH-1:0];
  assign w_unused = ^{wdata, addr_i[1:0]};
  assign w_pin    = (r_dir & r_data) | (~r_dir & r_filt);
  assign w_armed  = (r_arm_cnt == 2'd3);
  assign w_arming = (r_arm_cnt == 2'd2);
  assign w_rise   = r_filt & ~r_prev;
  assign w_fall   = ~r_filt & r_prev;
  assign w_set    = w_armed ? (((w_rise & r_rise_en) | (w_fall & r_fall_en)) & ~r_dir) : '0;
  assign w_w1c    = (write_en && (w_idx == REG_STATUS)) ? w_wd : '0;

  assign gpio_out = r_data;
  assign gpio_oe  = r_dir;
  assign irq_o    = |r_status;

  // Configuration register writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (write_en) begin
      case (w_idx)
        REG_DATA:    r_data    <= w_wd;
        REG_DIR:     r_dir     <= w_wd;
        REG_SET:     r_data    <= r_data | w_wd;
        REG_CLR:     r_data    <= r_data & ~w_wd;
        REG_RISE_EN: r_rise_en <= w_wd;
        REG_FALL_EN: r_fall_en <= w_wd;
        default:     ;
      endcase
    end
  end

  // Interrupt status: a new capture wins over a same-cycle W1C of that bit
  always_ff @(posedge clk) begin
    if (!rst_n) r_status <= '0;
    else        r_status <= (r_status & ~w_w1c) | w_set;
  end

  // Read data mux (pre-write values)
  always_comb begin
    w_rmux = '0;
    case (w_idx)
      REG_DATA:    w_rmux[GPIO_WIDTH-1:0] = r_data;
      REG_DIR:     w_rmux[GPIO_WIDTH-1:0] = r_dir;
      REG_PIN:     w_rmux[GPIO_WIDTH-1:0] = w_pin;
      REG_RISE_EN: w_rmux[GPIO_WIDTH-1:0] = r_rise_en;
      REG_FALL_EN: w_rmux[GPIO_WIDTH-1:0] = r_fall_en;
      REG_STATUS:  w_rmux[GPIO_WIDTH-1:0] = r_status;
      default:     w_rmux = '0;
    endcase
  end

  // Registered read response; rdata holds between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= read_en;
      if (read_en) rdata <= w_rmux;
    end
  end

  // Two-flop synchroniser for the asynchronous pads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  // Arming counter: edge capture held off until the input path has settled
  always_ff @(posedge clk) begin
    if (!rst_n)        r_arm_cnt <= '0;
    else if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [7:0] r_db_cnt [GPIO_WIDTH];

  // Debounce filter: accept a change only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt <= '0;
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) r_db_cnt[i] <= '0;
    end else if (w_arming) begin
      r_filt <= r_sync2;
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_filt[i]   <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  localparam int unsigned UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

  // Filter stage is a plain register of the synchroniser output
  always_ff @(posedge clk) begin
    if (!rst_n) r_filt <= '0;
    else        r_filt <= r_sync2;
  end
`endif

  // Edge reference. prev tracks filt every cycle regardless of DIR, so a DIR
  // 1->0 change always starts from an up-to-date reference (no false edge).
  // On the arming cycle both filt and prev take sync2 so no edge is seen.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_prev <= '0;
    else if (w_arming) r_prev <= r_sync2;
    else               r_prev <= r_filt;
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Testbench for gpio_irq_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_gpio_irq_ctrl;
  localparam int unsigned W  = 16;
  localparam int unsigned DC = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned WIN = DC;
`else
  localparam int unsigned WIN = 1;
`endif

  localparam logic [4:0] A_DATA = 5'h00, A_DIR = 5'h04, A_PIN = 5'h08, A_SET = 5'h0C,
                         A_CLR = 5'h10, A_RISE = 5'h14, A_FALL = 5'h18, A_STAT = 5'h1C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    addr_i;
  logic          write_en, read_en;
  logic [31:0]   wdata, rdata;
  logic          rvalid, irq_o;
  logic [W-1:0]  gpio_in, gpio_out, gpio_oe;

  always #5 clk = ~clk;

  gpio_irq_ctrl #(.GPIO_WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .write_en(write_en), .read_en(read_en),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq_o(irq_o)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural model state
  logic [W-1:0] m_data, m_dir, m_rise, m_fall, m_status, m_filt, m_prev;
  logic [31:0]  m_rdata;
  logic         m_rvalid;
  int unsigned  m_k;            // clock edges since reset released
  logic [W-1:0] pad_hist[$];    // pad value sampled at each edge, newest first
  logic [W-1:0] s2_hist[$];     // synchronised value seen at each edge, newest first
  logic [W-1:0] pad_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, using the inputs present at that edge
  task automatic m_edge();
    logic [W-1:0] s2, ev, wd, pin;
    logic         flip;
    if (!rst_n) begin
      m_data = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
      m_filt = '0; m_prev = '0; m_rdata = '0; m_rvalid = 1'b0; m_k = 0;
      pad_hist.delete(); pad_hist.push_front('0); pad_hist.push_front('0);
      s2_hist.delete();
      return;
    end
    m_k++;
    // a pad sample reaches the synchroniser output two edges later
    s2 = pad_hist[1];
    pad_hist.push_front(gpio_in);
    if (pad_hist.size() > 4) void'(pad_hist.pop_back());
    s2_hist.push_front(s2);
    if (s2_hist.size() > WIN) void'(s2_hist.pop_back());

    ev = '0;
    if (m_k >= 4) ev = ((m_filt & ~m_prev & m_rise) | (~m_filt & m_prev & m_fall)) & ~m_dir;

    pin = (m_dir & m_data) | (~m_dir & m_filt);
    m_rvalid = read_en;
    if (read_en) begin
      m_rdata = '0;
      case (addr_i[4:2])
        3'd0: m_rdata[W-1:0] = m_data;
        3'd1: m_rdata[W-1:0] = m_dir;
        3'd2: m_rdata[W-1:0] = pin;
        3'd5: m_rdata[W-1:0] = m_rise;
        3'd6: m_rdata[W-1:0] = m_fall;
        3'd7: m_rdata[W-1:0] = m_status;
        default: m_rdata = '0;
      endcase
    end
    wd = wdata[W-1:0];
    if (write_en) begin
      case (addr_i[4:2])
        3'd0: m_data = wd;
        3'd1: m_dir = wd;
        3'd3: m_data = m_data | wd;
        3'd4: m_data = m_data & ~wd;
        3'd5: m_rise = wd;
        3'd6: m_fall = wd;
        3'd7: m_status = m_status & ~wd;
        default: ;
      endcase
    end
    m_status = m_status | ev;

    if (m_k == 3) begin
      m_filt = s2;
      m_prev = s2;
    end else if (m_k > 3) begin
      m_prev = m_filt;
      // accept a change once the last WIN samples (all post-arming) disagree
      if (m_k - (WIN - 1) > 3) begin
        for (int i = 0; i < W; i++) begin
          flip = 1'b1;
          for (int j = 0; j < WIN; j++)
            if (s2_hist[j][i] == m_filt[i]) flip = 1'b0;
          if (flip) m_filt[i] = ~m_filt[i];
        end
      end
    end
  endtask

  task automatic check_all();
    chk("gpio_out", 32'(gpio_out), 32'(m_data));
    chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
    chk("irq_o", 32'(irq_o), 32'(|m_status));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic tick(input logic [4:0] a, input logic we, input logic re, input logic [31:0] wd);
    addr_i = a; write_en = we; read_en = re; wdata = wd; gpio_in = pad_now;
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(A_DATA, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    tick(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [4:0] a);
    tick(a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic do_reset(input logic [W-1:0] pad);
    pad_now = pad;
    rst_n = 1'b0;
    tick(A_DATA, 1'b0, 1'b0, 32'h0);
    tick(A_DATA, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  a;
    logic        we;
    logic        re;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] a, input logic we, input logic re,
                              input logic [31:0] wd, input logic c, input logic [31:0] e);
    vec_t v;
    v.a = a; v.we = we; v.re = re; v.wd = wd; v.chk_rd = c; v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    int   waited;

    rst_n = 1'b0; addr_i = '0; write_en = 1'b0; read_en = 1'b0; wdata = '0;
    pad_now = '0; gpio_in = '0;

    // Reset with every pad high: no IRQ after arming, PIN reflects pads
    do_reset(16'hFFFF);
    chk("reset_irq", 32'(irq_o), 32'h0);
    chk("reset_out", 32'(gpio_out), 32'h0);
    wr(A_RISE, 32'hFFFF);
    wr(A_FALL, 32'hFFFF);
    idle(10);
    rd(A_STAT); chk("reset_status", rdata, 32'h0);
    chk("reset_irq_after", 32'(irq_o), 32'h0);
    rd(A_PIN);  chk("reset_pin", rdata, 32'h0000FFFF);

    // Directed register vectors
    do_reset(16'h0000);
    vecs.push_back(mk(A_DATA, 1, 0, 32'h000000F0, 0, 32'h0));
    vecs.push_back(mk(A_SET,  1, 0, 32'h00000003, 0, 32'h0));
    vecs.push_back(mk(A_CLR,  1, 0, 32'h00000010, 0, 32'h0));
    vecs.push_back(mk(A_DATA, 0, 1, 32'h0,        1, 32'h000000E3));
    vecs.push_back(mk(A_SET,  0, 1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(A_CLR,  0, 1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(A_DIR,  1, 0, 32'h000000FF, 0, 32'h0));
    vecs.push_back(mk(A_DIR,  0, 1, 32'h0,        1, 32'h000000FF));
    vecs.push_back(mk(A_PIN,  0, 1, 32'h0,        1, 32'h000000E3));
    vecs.push_back(mk(A_DIR,  1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(A_DATA, 1, 1, 32'h00001234, 1, 32'h000000E3));
    vecs.push_back(mk(A_DATA, 0, 1, 32'h0,        1, 32'h00001234));
    vecs.push_back(mk(A_PIN,  1, 0, 32'h00005555, 0, 32'h0));
    vecs.push_back(mk(A_PIN,  0, 1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(A_RISE, 1, 0, 32'h000000FF, 0, 32'h0));
    vecs.push_back(mk(A_RISE, 0, 1, 32'h0,        1, 32'h000000FF));
    vecs.push_back(mk(A_FALL, 1, 0, 32'h0000ABCD, 0, 32'h0));
    vecs.push_back(mk(A_FALL, 0, 1, 32'h0,        1, 32'h0000ABCD));
    vecs.push_back(mk(A_SET,  1, 0, 32'hFFFF0000, 0, 32'h0));
    vecs.push_back(mk(5'h03,  0, 1, 32'h0,        1, 32'h00001234));
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].a, vecs[i].we, vecs[i].re, vecs[i].wd);
      if (vecs[i].chk_rd) begin
        chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
        chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'h1);
      end
    end
    chk("gpio_out_e3", 32'(gpio_out), 32'h00001234);

    // Edge capture and W1C
    do_reset(16'h0000);
    wr(A_RISE, 32'h0001);
    wr(A_FALL, 32'h0002);
    pad_now = 16'h0002;
    idle(4 + WIN + 2);
    rd(A_STAT); chk("edge_pre_status", rdata, 32'h0);
    pad_now = 16'h0001;
    waited = 0;
    while (!irq_o && waited < 8 + WIN) begin
      idle(1);
      waited++;
    end
    chk("edge_irq_rose", 32'(irq_o), 32'h1);
    rd(A_STAT); chk("edge_status", rdata, 32'h0003);
    wr(A_STAT, 32'h0001);
    rd(A_STAT); chk("edge_w1c0", rdata, 32'h0002);
    chk("edge_irq_still", 32'(irq_o), 32'h1);
    wr(A_STAT, 32'h0002);
    chk("edge_irq_clear", 32'(irq_o), 32'h0);

    // Capture and W1C of the same bit in one cycle: capture wins
    pad_now = 16'h0000;
    idle(4 + WIN + 2);
    wr(A_STAT, 32'hFFFF);
    pad_now = 16'h0001;
    idle(2 + WIN);
    wr(A_STAT, 32'h0001);
    rd(A_STAT); chk("collision_status", rdata, 32'h0001);

    // Output pins are masked from capture; PIN shows DATA
    wr(A_STAT, 32'hFFFF);
    wr(A_RISE, 32'h0001);
    wr(A_FALL, 32'h0001);
    wr(A_DIR, 32'h0001);
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 1) wr(A_SET, 32'h0001);
      else            wr(A_CLR, 32'h0001);
      pad_now[0] = (j % 2 == 0);
      idle(4 + WIN + 2);
      rd(A_PIN);  chk($sformatf("mask_pin%0d", j), 32'(rdata[0]), 32'(j % 2));
      rd(A_STAT); chk($sformatf("mask_status%0d", j), rdata, 32'h0);
    end
    wr(A_DIR, 32'h0000);
    idle(4 + WIN + 2);
    rd(A_STAT); chk("dir_release_status", rdata, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Short pulse rejected, long pulse accepted after 2+DC edges
    do_reset(16'h0000);
    wr(A_RISE, 32'h0004);
    idle(4);
    pad_now = 16'h0004;
    idle(DC - 1);
    pad_now = 16'h0000;
    idle(DC + 6);
    rd(A_PIN);  chk("db_short_pin", rdata, 32'h0);
    rd(A_STAT); chk("db_short_status", rdata, 32'h0);
    pad_now = 16'h0004;
    idle(1 + DC);
    rd(A_PIN);  chk("db_long_pin_early", 32'(rdata[2]), 32'h0);
    rd(A_PIN);  chk("db_long_pin", 32'(rdata[2]), 32'h1);
    idle(1);
    rd(A_STAT); chk("db_long_status", rdata, 32'h0004);
`endif

    // Randomized traffic against the model
    do_reset(16'h0000);
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] a;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 15) == 0) pad_now[b] = ~pad_now[b];
      a = 5'($urandom_range(0, 31));
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0 && a[4:2] == 3'd1)
        a = A_STAT;
      tick(a, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)));
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
